// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O bus controller: registered request/ack handshake between the CPU data port
// and N_SLOT peripherals, with address decode, wait states, unmapped and timeout errors.
module io_bus_ctrl #(
  parameter int unsigned                 ADDR_W    = 32,
  parameter int unsigned                 DATA_W    = 32,
  parameter int unsigned                 N_SLOT    = 4,
  parameter logic [N_SLOT*ADDR_W-1:0]    SLOT_BASE = {N_SLOT{32'hFFFFF000}},
  parameter logic [N_SLOT*ADDR_W-1:0]    SLOT_MASK = {N_SLOT{32'hFFFFFF00}},
  parameter int unsigned                 TIMEOUT   = 255,
  parameter logic [DATA_W-1:0]           ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_m_req,
  input  logic                       i_m_we,
  input  logic [ADDR_W-1:0]          i_m_addr,
  input  logic [DATA_W-1:0]          i_m_wdata,
  input  logic [DATA_W/8-1:0]        i_m_wstrb,
  output logic                       o_m_ready,
  output logic [DATA_W-1:0]          o_m_rdata,
  output logic                       o_m_err,
  output logic [N_SLOT-1:0]          o_s_sel,
  output logic                       o_s_we,
  output logic [ADDR_W-1:0]          o_s_addr,
  output logic [DATA_W-1:0]          o_s_wdata,
  output logic [DATA_W/8-1:0]        o_s_wstrb,
  input  logic [N_SLOT-1:0]          i_s_ack,
  input  logic [N_SLOT*DATA_W-1:0]   i_s_rdata
);

  localparam int unsigned IDX_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW    = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e             r_state, w_state_nxt;
  logic [N_SLOT-1:0]  r_sel, w_sel_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_we, w_we_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
  logic [SW-1:0]      r_wstrb, w_wstrb_nxt;
  logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
  logic               r_err, w_err_nxt;

  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_ack;
  logic [DATA_W-1:0]  w_slot_rdata;

  // Scan from the top down so the lowest-index hit is the last assignment and wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if ((i_m_addr & SLOT_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLOT_BASE[i*ADDR_W +: ADDR_W] & SLOT_MASK[i*ADDR_W +: ADDR_W])) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_ack        = i_s_ack[r_idx];
  assign w_slot_rdata = i_s_rdata[int'(r_idx)*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wstrb_nxt = r_wstrb;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (i_m_req) begin
          if (w_hit) begin
            w_we_nxt    = i_m_we;
            w_addr_nxt  = i_m_addr;
            w_wdata_nxt = i_m_wdata;
            w_wstrb_nxt = i_m_we ? i_m_wstrb : '0;
            w_sel_nxt   = N_SLOT'(1) << w_hit_idx;
            w_idx_nxt   = w_hit_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = StAccess;
          end else begin
            w_rdata_nxt = ERR_RDATA;
            w_err_nxt   = 1'b1;
            w_state_nxt = StResp;
          end
        end
      end
      StAccess: begin
        // Ack is checked first so it beats a timeout on the same cycle.
        if (w_ack) begin
          w_rdata_nxt = r_we ? '0 : w_slot_rdata;
          w_err_nxt   = 1'b0;
          w_sel_nxt   = '0;
          w_state_nxt = StResp;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rdata_nxt = ERR_RDATA;
          w_err_nxt   = 1'b1;
          w_sel_nxt   = '0;
          w_state_nxt = StResp;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wstrb <= w_wstrb_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_m_ready = (r_state == StResp);
  assign o_m_rdata = r_rdata;
  assign o_m_err   = r_err;
  assign o_s_sel   = r_sel;
  assign o_s_we    = r_we;
  assign o_s_addr  = r_addr;
  assign o_s_wdata = r_wdata;
  assign o_s_wstrb = r_wstrb;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: four slots with programmable wait states and stray acks.
module tb_io_bus_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_req, m_we;
  logic [31:0]   m_addr, m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_ready, m_err;
  logic [31:0]   m_rdata;
  logic [3:0]    s_sel;
  logic          s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_wstrb;
  logic [3:0]    s_ack;
  logic [127:0]  s_rdata;

  logic [7:0]    wcnt [4];
  logic [7:0]    wait_cyc [4];
  logic [3:0]    stray;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_bus_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .N_SLOT   (4),
    .SLOT_BASE(128'hFFFFF300_FFFFF200_FFFFF100_FFFFF000),
    .SLOT_MASK({4{32'hFFFFFF00}}),
    .TIMEOUT  (4),
    .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_m_req  (m_req),
    .i_m_we   (m_we),
    .i_m_addr (m_addr),
    .i_m_wdata(m_wdata),
    .i_m_wstrb(m_wstrb),
    .o_m_ready(m_ready),
    .o_m_rdata(m_rdata),
    .o_m_err  (m_err),
    .o_s_sel  (s_sel),
    .o_s_we   (s_we),
    .o_s_addr (s_addr),
    .o_s_wdata(s_wdata),
    .o_s_wstrb(s_wstrb),
    .i_s_ack  (s_ack),
    .i_s_rdata(s_rdata)
  );

  assign s_rdata = 128'h33333333_22222222_12345678_A0A0A0A0;

  // Slave i acks after wait_cyc[i] extra cycles of being selected (0xFF = never).
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) wcnt[i] <= s_sel[i] ? wcnt[i] + 8'd1 : 8'd0;
  end

  always_comb begin
    s_ack = '0;
    for (int i = 0; i < 4; i++)
      s_ack[i] = (s_sel[i] && (wcnt[i] == wait_cyc[i])) || stray[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat counts negedges from issue until m_ready is seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [3:0] stray_in,
                      output int lat, output logic [3:0] sel1, output int sel_cyc,
                      output int unstable);
    @(negedge clk);
    m_we = we; m_addr = addr; m_wdata = wdata; m_wstrb = strb; m_req = 1'b1;
    lat = 0; sel1 = '0; sel_cyc = 0; unstable = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        sel1 = s_sel;
        stray = stray_in;
        // Later input changes must not disturb the transaction in flight.
        m_addr = 32'h0000_0000; m_wdata = 32'h5555_5555; m_wstrb = 4'hC; m_we = ~we;
      end else begin
        stray = '0;
      end
      if (s_sel != 4'b0) begin
        sel_cyc++;
        if (s_wdata !== wdata || s_wstrb !== (we ? strb : 4'h0) || s_addr !== addr) unstable++;
      end
    end while (!m_ready && lat < 50);
    stray = '0;
    m_req = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'b0, m_ready}, 32'd0);
  endtask

  int         lat, sel_cyc, unstable;
  logic [3:0] sel1;

  initial begin
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    stray = '0;
    wait_cyc[0] = 8'd3; wait_cyc[1] = 8'd0; wait_cyc[2] = 8'd3; wait_cyc[3] = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, m_ready}, 32'd0);
    check("rst_sel", {28'b0, s_sel}, 32'd0);
    check("rst_rdata_err", m_rdata | {31'b0, m_err}, 32'd0);
    check("rst_s_bus", s_addr | s_wdata | {27'b0, s_we, s_wstrb}, 32'd0);
    rst = 1'b0;

    // Zero-wait read of slot 1; strobes must be zeroed on the slave side.
    xact(1'b0, 32'hFFFFF104, 32'h0, 4'hF, 4'h0, lat, sel1, sel_cyc, unstable);
    check("t1_sel", {28'b0, sel1}, 32'h2);
    check("t1_lat", lat, 2);
    check("t1_rdata", m_rdata, 32'h12345678);
    check("t1_err", {31'b0, m_err}, 32'd0);
    check("t1_s_addr", s_addr, 32'hFFFFF104);
    check("t1_s_wstrb", {28'b0, s_wstrb}, 32'd0);
    check("t1_stable", unstable, 0);

    // Three-wait-state write to slot 0.
    xact(1'b1, 32'hFFFFF010, 32'hA5A5A5A5, 4'b0011, 4'h0, lat, sel1, sel_cyc, unstable);
    check("t2_sel", {28'b0, sel1}, 32'h1);
    check("t2_lat", lat, 5);
    check("t2_err", {31'b0, m_err}, 32'd0);
    check("t2_rdata", m_rdata, 32'd0);
    check("t2_stable", unstable, 0);
    check("t2_s_we", {31'b0, s_we}, 32'd1);
    check("t2_s_wstrb", {28'b0, s_wstrb}, 32'h3);

    // Unmapped address.
    xact(1'b0, 32'h00001000, 32'h0, 4'h0, 4'h0, lat, sel1, sel_cyc, unstable);
    check("t3_sel", {28'b0, sel1}, 32'd0);
    check("t3_sel_cyc", sel_cyc, 0);
    check("t3_lat", lat, 1);
    check("t3_rdata", m_rdata, 32'hDEADBEEF);
    check("t3_err", {31'b0, m_err}, 32'd1);

    // Timeout on slot 3, which never acks.
    xact(1'b0, 32'hFFFFF300, 32'h0, 4'h0, 4'h0, lat, sel1, sel_cyc, unstable);
    check("t4_sel", {28'b0, sel1}, 32'h8);
    check("t4_sel_cyc", sel_cyc, 4);
    check("t4_lat", lat, 5);
    check("t4_rdata", m_rdata, 32'hDEADBEEF);
    check("t4_err", {31'b0, m_err}, 32'd1);
    check("t4_sel_clr", {28'b0, s_sel}, 32'd0);

    // Ack on the timeout boundary, with stray acks from slots 0 and 3 early on.
    xact(1'b0, 32'hFFFFF2FC, 32'h0, 4'h0, 4'b1001, lat, sel1, sel_cyc, unstable);
    check("t5_sel", {28'b0, sel1}, 32'h4);
    check("t5_lat", lat, 5);
    check("t5_rdata", m_rdata, 32'h22222222);
    check("t5_err", {31'b0, m_err}, 32'd0);

    // Reset while slot 0 is in its wait states.
    @(negedge clk);
    m_we = 1'b1; m_addr = 32'hFFFFF020; m_wdata = 32'hCAFEF00D; m_wstrb = 4'hF; m_req = 1'b1;
    @(negedge clk);
    check("t6_sel_pre", {28'b0, s_sel}, 32'h1);
    rst = 1'b1; m_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_sel", {28'b0, s_sel}, 32'd0);
    check("t6_ready", {31'b0, m_ready}, 32'd0);
    check("t6_s_bus", s_addr | s_wdata | {27'b0, s_we, s_wstrb}, 32'd0);
    check("t6_rdata_err", m_rdata | {31'b0, m_err}, 32'd0);
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ready) lat++;
    end
    check("t6_no_ready", lat, 0);
    xact(1'b0, 32'hFFFFF100, 32'h0, 4'h0, 4'h0, lat, sel1, sel_cyc, unstable);
    check("t6_after_lat", lat, 2);
    check("t6_after_rdata", m_rdata, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
